// File: rtl/ras_ckpt_stack_if.sv
// Handshake bundle for the checkpointed return-address stack.
// master drives call/return/checkpoint requests, slave answers.
interface ras_ckpt_stack_if #(
  parameter int WIDTH = 32,
  parameter int PTRW  = 4,
  parameter int CKW   = 2
);
  logic             push;
  logic [WIDTH-1:0] din;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [WIDTH-1:0] top_data;
  logic             top_valid;
  logic [PTRW:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
  logic             ckpt_save;
  logic [CKW-1:0]   ckpt_save_id;
  logic             ckpt_restore;
  logic [CKW-1:0]   ckpt_rest_id;
  logic             restore_err;

  modport master (
    output push, din, pop,
    output ckpt_save, ckpt_save_id,
    output ckpt_restore, ckpt_rest_id,
    input  pop_data, pop_valid,
    input  top_data, top_valid,
    input  count, full, empty,
    input  overflow, underflow,
    input  restore_err
  );

  modport slave (
    input  push, din, pop,
    input  ckpt_save, ckpt_save_id,
    input  ckpt_restore, ckpt_rest_id,
    output pop_data, pop_valid,
    output top_data, top_valid,
    output count, full, empty,
    output overflow, underflow,
    output restore_err
  );
endinterface

// File: rtl/ras_ckpt_stack.sv
// Return-address stack with recursion counters, circular overflow
// and compact checkpoint snapshots for mispredict recovery.
module ras_ckpt_stack #(
  parameter int DEPTH = 16,
  parameter int PTRW  = 4,
  parameter int WIDTH = 32,
  parameter int CNTW  = 7,
  parameter int NCKPT = 4,
  parameter int CKW   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ras_ckpt_stack_if.slave  bus
);
  localparam logic [PTRW-1:0] P1   = PTRW'(1);
  localparam logic [PTRW:0]   C1   = (PTRW+1)'(1);
  localparam logic [PTRW:0]   CMAX = (PTRW+1)'(DEPTH);
  localparam logic [CNTW-1:0] K1   = CNTW'(1);
  localparam logic [CNTW-1:0] KMAX = '1;

  logic [CNTW-1:0]  cnt_q  [DEPTH];
  logic [CNTW-1:0]  cnt_d  [DEPTH];
  logic [WIDTH-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0] addr_d [DEPTH];
  logic [PTRW-1:0]  ptr_q, ptr_d;
  logic [PTRW:0]    count_q, count_d;

  logic             ckv_q  [NCKPT];
  logic             ckv_d  [NCKPT];
  logic [PTRW-1:0]  ckp_q  [NCKPT];
  logic [PTRW-1:0]  ckp_d  [NCKPT];
  logic [PTRW:0]    ckc_q  [NCKPT];
  logic [PTRW:0]    ckc_d  [NCKPT];
  logic [CNTW-1:0]  ckk_q  [NCKPT];
  logic [CNTW-1:0]  ckk_d  [NCKPT];
  logic [WIDTH-1:0] cka_q  [NCKPT];
  logic [WIDTH-1:0] cka_d  [NCKPT];

  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             pvld_q, pvld_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rerr_q, rerr_d;

  logic [PTRW-1:0]  top_idx;
  logic [PTRW-1:0]  rst_idx;
  logic [CNTW-1:0]  top_cnt;
  logic [WIDTH-1:0] top_addr;
  logic             nonempty;
  logic             push_new;

  assign top_idx  = ptr_q - P1;
  assign rst_idx  = ckp_q[bus.ckpt_rest_id] - P1;
  assign top_cnt  = cnt_q[top_idx];
  assign top_addr = addr_q[top_idx];
  assign nonempty = (count_q != '0);

  always_comb begin
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    ckv_d    = ckv_q;
    ckp_d    = ckp_q;
    ckc_d    = ckc_q;
    ckk_d    = ckk_q;
    cka_d    = cka_q;
    pdata_d  = pdata_q;
    pvld_d   = 1'b0;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    rerr_d   = 1'b0;
    push_new = 1'b0;

    if (bus.ckpt_restore) begin
      if (ckv_q[bus.ckpt_rest_id]) begin
        ptr_d   = ckp_q[bus.ckpt_rest_id];
        count_d = ckc_q[bus.ckpt_rest_id];
        if (ckc_q[bus.ckpt_rest_id] != '0) begin
          cnt_d[rst_idx]  = ckk_q[bus.ckpt_rest_id];
          addr_d[rst_idx] = cka_q[bus.ckpt_rest_id];
        end
      end else begin
        rerr_d = 1'b1;
      end
    end else begin
      if (bus.pop && nonempty) begin
        pdata_d = top_addr;
        pvld_d  = 1'b1;
      end
      udf_d = bus.pop && !nonempty;

      unique case (1'b1)
        bus.push && !(bus.pop && nonempty): begin
          if (nonempty && top_addr == bus.din && top_cnt != KMAX)
            cnt_d[top_idx] = top_cnt + K1;
          else
            push_new = 1'b1;
        end
        bus.pop && nonempty && !bus.push: begin
          if (top_cnt > K1) begin
            cnt_d[top_idx] = top_cnt - K1;
          end else begin
            cnt_d[top_idx]  = '0;
            addr_d[top_idx] = '0;
            ptr_d           = top_idx;
            count_d         = count_q - C1;
          end
        end
        bus.push && bus.pop && nonempty: begin
          // return-then-call: reuse the top slot when it is a lone entry
          if (top_cnt <= K1) begin
            cnt_d[top_idx]  = K1;
            addr_d[top_idx] = bus.din;
          end else if (bus.din != top_addr) begin
            cnt_d[top_idx] = top_cnt - K1;
            push_new       = 1'b1;
          end
        end
        default: ;
      endcase

      if (push_new) begin
        cnt_d[ptr_q]  = K1;
        addr_d[ptr_q] = bus.din;
        ptr_d         = ptr_q + P1;
        if (count_q != CMAX) count_d = count_q + C1;
        else                 ovf_d   = 1'b1;
      end
    end

    if (bus.ckpt_save) begin
      ckv_d[bus.ckpt_save_id] = 1'b1;
      ckp_d[bus.ckpt_save_id] = ptr_q;
      ckc_d[bus.ckpt_save_id] = count_q;
      ckk_d[bus.ckpt_save_id] = nonempty ? top_cnt  : '0;
      cka_d[bus.ckpt_save_id] = nonempty ? top_addr : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      for (int i = 0; i < NCKPT; i++) begin
        ckv_q[i] <= 1'b0;
        ckp_q[i] <= '0;
        ckc_q[i] <= '0;
        ckk_q[i] <= '0;
        cka_q[i] <= '0;
      end
      ptr_q   <= '0;
      count_q <= '0;
      pdata_q <= '0;
      pvld_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ckv_q   <= ckv_d;
      ckp_q   <= ckp_d;
      ckc_q   <= ckc_d;
      ckk_q   <= ckk_d;
      cka_q   <= cka_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      pdata_q <= pdata_d;
      pvld_q  <= pvld_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      rerr_q  <= rerr_d;
    end
  end

  assign bus.pop_data    = pdata_q;
  assign bus.pop_valid   = pvld_q;
  assign bus.top_data    = top_addr;
  assign bus.top_valid   = nonempty;
  assign bus.count       = count_q;
  assign bus.full        = (count_q == CMAX);
  assign bus.empty       = !nonempty;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
  assign bus.restore_err = rerr_q;
endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Scoreboard bench for ras_ckpt_stack: directed plan plus random
// traffic against a stack-level reference model.
module tb_ras_ckpt_stack;
  localparam int DEPTH = 16;
  localparam int PTRW  = 4;
  localparam int WIDTH = 32;
  localparam int CNTW  = 3;
  localparam int NCKPT = 4;
  localparam int CKW   = 2;
  localparam int KMAX  = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ras_ckpt_stack_if #(.WIDTH(WIDTH), .PTRW(PTRW), .CKW(CKW)) bus();

  ras_ckpt_stack #(
    .DEPTH(DEPTH), .PTRW(PTRW), .WIDTH(WIDTH),
    .CNTW(CNTW), .NCKPT(NCKPT), .CKW(CKW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    int count;
    int top;
    bit pv;
    int pa;
    bit ovf;
    bit udf;
    bit rerr;
  } exp_t;

  exp_t sq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // reference: a circular array of {addr,count} frames
  int m_addr [DEPTH];
  int m_cnt  [DEPTH];
  int m_ptr, m_count;
  bit ck_v   [NCKPT];
  int ck_ptr [NCKPT];
  int ck_cnt [NCKPT];
  int ck_tk  [NCKPT];
  int ck_ta  [NCKPT];

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic int below(int p);
    return (p + DEPTH - 1) % DEPTH;
  endfunction

  task automatic frame_new(input int a, inout bit ovf);
    m_addr[m_ptr] = a;
    m_cnt[m_ptr]  = 1;
    m_ptr = (m_ptr + 1) % DEPTH;
    if (m_count < DEPTH) m_count++;
    else ovf = 1'b1;
  endtask

  task automatic step(input bit r, input bit pu, input int d,
                      input bit po, input bit sv, input int sid,
                      input bit rs, input int rid);
    exp_t e;
    int   t, sp, sc, sk, sa;
    bit   hit;
    @(negedge clk);
    rst              = r;
    bus.push         = pu;
    bus.din          = WIDTH'(d);
    bus.pop          = po;
    bus.ckpt_save    = sv;
    bus.ckpt_save_id = CKW'(sid);
    bus.ckpt_restore = rs;
    bus.ckpt_rest_id = CKW'(rid);
    e = '{default: 0};
    if (r) begin
      foreach (m_addr[i]) begin m_addr[i] = 0; m_cnt[i] = 0; end
      foreach (ck_v[i]) ck_v[i] = 1'b0;
      m_ptr = 0;
      m_count = 0;
    end else begin
      t   = below(m_ptr);
      hit = (m_count > 0);
      sp  = m_ptr;
      sc  = m_count;
      sk  = hit ? m_cnt[t] : 0;
      sa  = hit ? m_addr[t] : 0;
      if (rs) begin
        if (ck_v[rid]) begin
          m_ptr   = ck_ptr[rid];
          m_count = ck_cnt[rid];
          if (m_count > 0) begin
            m_cnt[below(m_ptr)]  = ck_tk[rid];
            m_addr[below(m_ptr)] = ck_ta[rid];
          end
        end else e.rerr = 1'b1;
      end else begin
        if (po && !hit) e.udf = 1'b1;
        if (po && hit) begin e.pv = 1'b1; e.pa = m_addr[t]; end
        if (pu && !(po && hit)) begin
          if (hit && m_addr[t] == d && m_cnt[t] < KMAX) m_cnt[t]++;
          else frame_new(d, e.ovf);
        end else if (po && hit && !pu) begin
          if (m_cnt[t] > 1) m_cnt[t]--;
          else begin
            m_cnt[t] = 0; m_addr[t] = 0;
            m_ptr = t; m_count--;
          end
        end else if (po && hit && pu) begin
          if (m_cnt[t] == 1) m_addr[t] = d;
          else if (d != m_addr[t]) begin
            m_cnt[t]--;
            frame_new(d, e.ovf);
          end
        end
      end
      if (sv) begin
        ck_v[sid] = 1'b1;
        ck_ptr[sid] = sp; ck_cnt[sid] = sc;
        ck_tk[sid] = sk;  ck_ta[sid] = sa;
      end
    end
    e.count = m_count;
    e.top   = (m_count > 0) ? m_addr[below(m_ptr)] : 0;
    @(posedge clk);
    #1;
    sq.push_back(e);
  endtask

  task automatic push(input int d);
    step(0, 1, d, 0, 0, 0, 0, 0);
  endtask
  task automatic pop();
    step(0, 0, 0, 1, 0, 0, 0, 0);
  endtask
  task automatic do_rst();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sq.size() != 0) begin
        e = sq.pop_front();
        chk("count", bus.count, e.count);
        chk("full", bus.full, e.count == DEPTH);
        chk("empty", bus.empty, e.count == 0);
        chk("top_valid", bus.top_valid, e.count != 0);
        if (e.count != 0) chk("top_data", bus.top_data, e.top);
        chk("pop_valid", bus.pop_valid, e.pv);
        if (bus.pop_valid && e.pv) chk("pop_data", bus.pop_data, e.pa);
        chk("overflow", bus.overflow, e.ovf);
        chk("underflow", bus.underflow, e.udf);
        chk("restore_err", bus.restore_err, e.rerr);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int a, wait_n;
    bus.push = 0; bus.din = '0; bus.pop = 0;
    bus.ckpt_save = 0; bus.ckpt_save_id = '0;
    bus.ckpt_restore = 0; bus.ckpt_rest_id = '0;

    do_rst();
    chk("rst pop_data", bus.pop_data, 0);
    chk("rst count", bus.count, 0);

    push('h100); push('h200); push('h300);
    chk("tp1 count", bus.count, 3);
    chk("tp1 top", bus.top_data, 'h300);
    pop(); chk("tp1 pop0", bus.pop_data, 'h300);
    pop(); chk("tp1 pop1", bus.pop_data, 'h200);
    pop(); chk("tp1 pop2", bus.pop_data, 'h100);
    chk("tp1 empty", bus.empty, 1);

    repeat (5) push('h400);
    chk("tp2 count", bus.count, 1);
    for (int i = 0; i < 5; i++) begin
      pop(); chk("tp2 pop", bus.pop_data, 'h400);
    end
    chk("tp2 count0", bus.count, 0);
    pop();
    chk("tp2 udf", bus.underflow, 1);
    chk("tp2 pv", bus.pop_valid, 0);

    repeat (KMAX + 1) push('h500);
    chk("tp3 sat count", bus.count, 2);
    do_rst();

    for (int i = 0; i < 17; i++) begin
      push('h1000 + 16 * i);
      if (i == 15) chk("tp4 no ovf", bus.overflow, 0);
    end
    chk("tp4 ovf", bus.overflow, 1);
    chk("tp4 count", bus.count, 16);
    for (int i = 16; i >= 1; i--) begin
      pop(); chk("tp4 pop", bus.pop_data, 'h1000 + 16 * i);
    end
    chk("tp4 empty", bus.empty, 1);

    do_rst();
    push('hA0); push('hB0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    push('hC0); push('hD0); pop();
    step(0, 0, 0, 0, 0, 0, 1, 1);
    chk("tp5 count", bus.count, 2);
    chk("tp5 top", bus.top_data, 'hB0);
    step(0, 0, 0, 0, 0, 0, 1, 2);
    chk("tp5 rerr", bus.restore_err, 1);
    chk("tp5 count2", bus.count, 2);

    push('h600);
    step(0, 1, 'h700, 1, 0, 0, 0, 0);
    chk("tp6 pop", bus.pop_data, 'h600);
    chk("tp6 top", bus.top_data, 'h700);
    chk("tp6 count", bus.count, 3);

    step(0, 0, 0, 0, 1, 0, 0, 0);
    push('h800);
    step(0, 0, 0, 0, 1, 0, 1, 0);
    chk("tp7 count", bus.count, 3);
    chk("tp7 top", bus.top_data, 'h700);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("tp7 slot count", bus.count, 4);
    chk("tp7 slot top", bus.top_data, 'h800);

    for (int n = 0; n < 4000; n++) begin
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                      : int'($urandom_range(16, 19));
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 2) != 0, a,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0, int'($urandom_range(0, NCKPT - 1)),
           $urandom_range(0, 11) == 0, int'($urandom_range(0, NCKPT - 1)));
    end

    @(negedge clk);
    bus.push = 0; bus.pop = 0;
    bus.ckpt_save = 0; bus.ckpt_restore = 0;
    wait_n = 0;
    while (sq.size() != 0 && wait_n < 20) begin
      @(posedge clk);
      wait_n++;
    end
    chk("drain", sq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ras_ckpt_stack.md
Name: ras_ckpt_stack

Overview:
- Parametrised return-address stack with recursion-count compression, circular overflow and checkpoint save/restore for branch-mispredict recovery.
- Sits in the fetch/branch-predict path: calls push, returns pop, and redirects restore a saved snapshot.
- Generalises the fixed 16-entry reload stack.
  - Full-array reload is replaced by NCKPT compact snapshots.
  - Adds simultaneous push+pop, counter saturation and over/underflow reporting.

Parameters:
- DEPTH, 16, number of stack entries (power of 2).
- PTRW, 4, pointer width, log2(DEPTH).
- WIDTH, 32, return-address width.
- CNTW, 7, recursion-counter width per entry.
- NCKPT, 4, number of checkpoint slots.
- CKW, 2, checkpoint id width, log2(NCKPT).

Ports:
- Clk  in  1  clock.
- Rest  in  1  synchronous reset, active-high.
- Push  in  1  push DIN this cycle.
- DIN  in  WIDTH  address to push.
- Pop  in  1  pop top this cycle.
- PopData  out  WIDTH  popped address, registered.
- PopValid  out  1  pulses the cycle after an accepted pop.
- TopData  out  WIDTH  current top address, combinational from state.
- TopValid  out  1  Count!=0.
- Count  out  PTRW+1  number of valid entries, 0..DEPTH.
- Full  out  1  Count==DEPTH.
- Empty  out  1  Count==0.
- Overflow  out  1  registered pulse: push overwrote the oldest entry.
- Underflow  out  1  registered pulse: pop while empty.
- CkptSave  in  1  save snapshot into slot CkptSaveId.
- CkptSaveId  in  CKW  save slot.
- CkptRestore  in  1  restore snapshot from slot CkptRestId.
- CkptRestId  in  CKW  restore slot.
- RestoreErr  out  1  registered pulse: restore from an invalid slot.

Behaviour:
- State:
  - Entry[i] = {cnt[CNTW], addr[WIDTH]}.
  - Ptr = write pointer, modulo DEPTH. Top = Entry[Ptr-1].
  - Count = number of valid entries.
- Reset (Rest=1 at posedge):
  - Ptr=0, Count=0, all entries 0, all checkpoint valid bits 0.
  - PopData=0; PopValid, Overflow, Underflow, RestoreErr = 0.
- Push only:
  - Merge case (Count>0, Top.addr==DIN, Top.cnt!=all-ones): Top.cnt+1; Ptr and Count unchanged.
  - Otherwise: Entry[Ptr]={1,DIN}, Ptr+1.
    - If Count<DEPTH: Count+1.
    - Else Count stays DEPTH, the oldest entry is overwritten, and Overflow pulses next cycle.
- Pop only:
  - Count==0: no state change; Underflow pulses; PopValid=0.
  - Else PopData<=Top.addr and PopValid=1 next cycle.
    - If Top.cnt>1: Top.cnt-1.
    - Else: Top cleared, Ptr-1, Count-1.
- Push+Pop same cycle (return followed by call):
  - Count==0: treated as push only, plus Underflow pulse.
  - Top.cnt==1: Top overwritten with {1,DIN}; Ptr and Count unchanged.
  - Top.cnt>1 and DIN==Top.addr: no state change.
  - Top.cnt>1 and DIN!=Top.addr: Top.cnt-1, then DIN pushed as a new entry (full rule applies).
  - PopData/PopValid as for a normal pop.
- Checkpoint save:
  - Slot[CkptSaveId] <= {valid=1, Ptr, Count, Top} using pre-update state of this cycle.
  - Count==0 saves Top=0.
- Checkpoint restore (slot valid):
  - Ptr, Count <= saved values.
  - If saved Count>0: Entry[saved Ptr-1] <= saved Top.
  - Push/Pop in the same cycle are ignored: no PopValid, no Overflow/Underflow.
- Checkpoint restore (slot invalid): no state change; RestoreErr pulses; Push/Pop are still ignored.
- Save+Restore same cycle:
  - Restore reads the old slot contents.
  - The save writes the pre-restore state.
  - If the ids are equal, the slot ends holding the pre-restore snapshot.
- Pointer arithmetic wraps modulo DEPTH. Counter arithmetic never wraps: saturation forces a new entry.
- All pulse outputs are high for exactly one cycle.
- Rest asserted mid-sequence overrides every other input that cycle.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 → Count=3, TopData=0x300. Three pops → PopData 0x300, 0x200, 0x100; then Empty=1.
- Push 0x400 five times → Count=1, Top.cnt=5. Five pops each return 0x400 → Count=0. A sixth pop → Underflow=1, PopValid=0.
- CNTW=2: push 0x500 four times → first three merge (cnt=3), fourth creates a new entry → Count=2.
- Push 17 distinct addresses (DEPTH=16) → Overflow pulses on the 17th, Count=16. 16 pops return the 17th down to the 2nd address.
- Push A, B; save slot 1; push C, D; pop once; restore slot 1 → Count=2, TopData=B. Restore slot 2 (never saved) → RestoreErr=1, state unchanged.
- Top={cnt 1, 0x600}: Push+Pop with DIN=0x700 → PopData=0x600, TopData=0x700, Count unchanged.
- Same-cycle save+restore with equal ids → restore applies the old snapshot, and the slot then holds the pre-restore snapshot.
